note_scheduler: RTL and testbench
=================================

# note_scheduler

Sequences a song chart onto a pool of falling-arrow dropper slots, one launch per frame at most. It sits between the keyboard/game-control logic and the dropper instances: it counts frames, issues one-cycle launch pulses with lane assignments to free slots, and gathers per-slot hit/miss pulses into score, combo and miss totals. It owns the global game state (idle / playing / draining / done) so individual droppers no longer decode start and restart keys themselves.

## Interface
Parameters:
- NUM_SLOTS, 8, number of dropper slots managed (2..16)
- CHART_LEN, 32, chart ROM depth in entries
- BONUS_COMBO, 10, combo threshold at which hits earn bonus points

Ports:
- frame_clk  in  1  frame-rate clock
- Reset  in  1  synchronous, active-high; clock frame_clk
- keycode  in  8  primary key code
- keycode_second  in  8  secondary key code
- slot_busy  in  NUM_SLOTS  1 = slot has an arrow in flight
- slot_hit  in  NUM_SLOTS  one-cycle pulse, slot scored a hit
- slot_miss  in  NUM_SLOTS  one-cycle pulse, arrow reached bottom unhit
- launch  out  NUM_SLOTS  one-hot, one-cycle start pulse to a slot
- launch_lane  out  2  lane for the slot being launched; valid with launch
- score  out  16  accumulated score, saturating
- combo  out  8  consecutive hits, saturating at 255
- miss_cnt  out  8  misses plus dropped notes, saturating at 255
- game_state  out  2  IDLE=0, PLAY=1, DRAIN=2, DONE=3

## Operation
- Chart entry: 12-bit due frame + 2-bit lane. Entries are sorted ascending by due frame. Due frame 12'hFFF marks the end of the chart.
- On Reset, all outputs are 0, state is IDLE, frame_cnt is 0 and chart pointer is 0.
- IDLE: when keycode or keycode_second equals 8'h2c, the block goes to PLAY. On entry to PLAY it clears score, combo, miss_cnt and frame_cnt, and fetches entry 0.
- PLAY: frame_cnt increments every cycle and saturates at 12'hFFE. An entry is due when its due frame <= frame_cnt.
  - If a slot is free, the entry is launched and the next entry is fetched.
  - A slot is free when slot_busy=0 and it was not launched in the previous two cycles, which covers busy-flag lag.
  - The lowest-index free slot wins.
- Due entry with no free slot: the entry is discarded, miss_cnt increments, combo clears, and the next entry is fetched.
- End marker fetched in PLAY: go to DRAIN.
- DRAIN: when slot_busy is all zero and no hit or miss pulse is present this cycle, go to DONE.
- DONE: when either keycode equals 8'h01, go to IDLE. Score, combo and miss_cnt hold their values until the next PLAY entry.
- Scoring, evaluated every cycle in PLAY and DRAIN:
  - h = popcount(slot_hit), m = popcount(slot_miss).
  - score += h*10, plus h*5 if the current combo >= BONUS_COMBO. score saturates at 16'hFFFF.
  - If m>0, combo goes to 0. Otherwise combo += h, saturating.
  - miss_cnt += m, plus 1 for a discarded note. All counts saturate.
- Hit and miss pulses arriving in IDLE or DONE are ignored.
- Start and restart keys are ignored in any state other than the one listed above.

## Timing
- The chart ROM has a 1-cycle synchronous read. Fetching the next entry costs one bubble cycle, so the peak launch rate is 1 every 2 cycles. Same-frame entries launch on consecutive even cycles, late by the bubble count.
- Due detection happens in cycle t. launch and launch_lane are registered and asserted in cycle t+1, for exactly one cycle.
- score, combo and miss_cnt update the cycle after the corresponding pulse.
- game_state is registered and changes the cycle after the triggering condition.
- Reset mid-PLAY: the next cycle shows IDLE with all outputs 0, and any pending launch is cancelled.

## Structure
- rhythm_pkg holds:
  - chart_entry_t struct {due[11:0], lane[1:0]}
  - game_state_t enum
  - KEY_START=8'h2c and KEY_RESTART=8'h01
  - HIT_POINTS=10, BONUS_POINTS=5
  - CHART_END=12'hFFF
- Sub-module chart_rom: a synchronous-read ROM of chart_entry_t, CHART_LEN deep, initialized from a memory file.
- The scheduler itself contains:
  - state FSM
  - frame counter
  - entry register
  - free-slot priority encoder
  - recent-launch mask
  - popcount and saturating accumulators

## Test plan
- Reset, then keycode=8'h2c: game_state goes IDLE→PLAY. A chart of {5,lane0},{5,lane2},END gives launch=8'b0000_0001 with lane 0 at frame 6, then launch=8'b0000_0010 with lane 2 two cycles later.
- Hold slot_busy=8'hFF when an entry falls due: no launch occurs, miss_cnt=1, combo=0, and the next entry is fetched.
- Send 12 single-slot slot_hit pulses, then 2 simultaneous hits: score=120 and combo=12 after the 12 hits; score=150 and combo=14 after the pair.
- Send slot_hit=8'h03 and slot_miss=8'h04 in the same cycle with combo=5: score increases by 20, combo=0, miss_cnt increases by 1.
- After the end marker, hold slot_busy≠0: state stays DRAIN. Clearing busy gives DONE the next cycle; keycode_second=8'h01 then gives IDLE.
- Assert Reset while launch is pending in PLAY: launch stays 0, all outputs are 0 the next cycle, and state is IDLE.

Source files
------------

// File: rtl/rhythm_pkg.sv
// ---------------------------------------------------------------------------
// rhythm_pkg
// Shared types and constants for the rhythm-game note scheduler.
//   chart_entry_t : one chart ROM word, due frame plus lane
//   game_state_t  : global game state as seen on game_state
//   KEY_*         : key codes that start and restart a song
//   *_POINTS      : score awarded per hit, and the extra per hit at high combo
//   CHART_END     : due-frame value that terminates a chart
//   popcount16    : number of set bits in a pulse vector of up to 16 slots
// ---------------------------------------------------------------------------
package rhythm_pkg;

    typedef struct packed {
        logic [11:0] due;
        logic [1:0]  lane;
    } chart_entry_t;

    typedef enum logic [1:0] {
        GS_IDLE  = 2'd0,
        GS_PLAY  = 2'd1,
        GS_DRAIN = 2'd2,
        GS_DONE  = 2'd3
    } game_state_t;

    localparam int          ENTRY_W      = $bits(chart_entry_t);
    localparam logic [7:0]  KEY_START    = 8'h2c;
    localparam logic [7:0]  KEY_RESTART  = 8'h01;
    localparam int          HIT_POINTS   = 10;
    localparam int          BONUS_POINTS = 5;
    localparam logic [11:0] CHART_END    = 12'hFFF;

    // The frame counter stops one short of the end marker so that the
    // marker can never compare as due.
    localparam logic [11:0] FRAME_MAX    = 12'hFFE;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'b0000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/chart_rom.sv
// ---------------------------------------------------------------------------
// chart_rom
// Song chart storage with a one-cycle synchronous read. The ROM image is
// handed in as a flat parameter (entry i at INIT[i*ENTRY_W +: ENTRY_W]) so
// the build flow can generate it from the chart memory file. Locations past
// DEPTH, up to the next power of two, read back as end markers.
//   frame_clk : frame-rate clock
//   addr_i    : entry index to read
//   data_o    : entry at the address presented on the previous clock
// ---------------------------------------------------------------------------
module chart_rom
    import rhythm_pkg::*;
#(
    parameter int                       DEPTH = 32,
    parameter int                       AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter logic [DEPTH*ENTRY_W-1:0] INIT  = '1
) (
    input  logic          frame_clk,
    input  logic [AW-1:0] addr_i,
    output chart_entry_t  data_o
);

    chart_entry_t image [2**AW];
    chart_entry_t data_q;

    for (genvar g = 0; g < 2**AW; g++) begin : g_image
        if (g < DEPTH) begin : g_used
            assign image[g] = chart_entry_t'(INIT[g*ENTRY_W +: ENTRY_W]);
        end else begin : g_pad
            assign image[g] = '{due: CHART_END, lane: 2'd0};
        end
    end

    always_ff @(posedge frame_clk) begin
        data_q <= image[addr_i];
    end

    assign data_o = data_q;

endmodule

// File: rtl/note_scheduler.sv
// ---------------------------------------------------------------------------
// note_scheduler
// Walks a song chart against a frame counter and launches each due note on
// the lowest free dropper slot, one launch per two cycles at most. Collects
// per-slot hit/miss pulses into saturating score, combo and miss totals and
// owns the global game state.
//   frame_clk, Reset   : clock and synchronous active-high reset
//   keycode(_second)   : keyboard codes; start in IDLE, restart in DONE
//   slot_busy          : per-slot arrow-in-flight flags
//   slot_hit/slot_miss : per-slot one-cycle scoring pulses
//   launch/launch_lane : one-hot launch pulse and the lane for that arrow
//   score/combo/miss_cnt : running totals
//   game_state         : IDLE=0, PLAY=1, DRAIN=2, DONE=3
// ---------------------------------------------------------------------------
module note_scheduler
    import rhythm_pkg::*;
#(
    parameter int                           NUM_SLOTS   = 8,
    parameter int                           CHART_LEN   = 32,
    parameter int                           BONUS_COMBO = 10,
    parameter logic [CHART_LEN*ENTRY_W-1:0] CHART_INIT  = '1
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic [7:0]           keycode,
    input  logic [7:0]           keycode_second,
    input  logic [NUM_SLOTS-1:0] slot_busy,
    input  logic [NUM_SLOTS-1:0] slot_hit,
    input  logic [NUM_SLOTS-1:0] slot_miss,
    output logic [NUM_SLOTS-1:0] launch,
    output logic [1:0]           launch_lane,
    output logic [15:0]          score,
    output logic [7:0]           combo,
    output logic [7:0]           miss_cnt,
    output logic [1:0]           game_state
);

    localparam int AW = (CHART_LEN > 1) ? $clog2(CHART_LEN) : 1;

    localparam logic [1:0] S_IDLE  = GS_IDLE;
    localparam logic [1:0] S_PLAY  = GS_PLAY;
    localparam logic [1:0] S_DRAIN = GS_DRAIN;
    localparam logic [1:0] S_DONE  = GS_DONE;

    localparam logic [AW-1:0] LAST_PTR = AW'(CHART_LEN - 1);

    logic [1:0]           state_q,      state_d;
    logic [11:0]          frameCnt_q,   frameCnt_d;
    logic [AW-1:0]        ptr_q,        ptr_d;
    logic                 entryVld_q,   entryVld_d;
    logic [NUM_SLOTS-1:0] launch_q,     launch_d;
    logic [NUM_SLOTS-1:0] launchPrev_q;
    logic [1:0]           lane_q,       lane_d;
    logic [15:0]          score_q,      score_d;
    logic [7:0]           combo_q,      combo_d;
    logic [7:0]           miss_q,       miss_d;

    chart_entry_t         entry;
    logic                 startGame;
    logic                 restartKey;
    logic                 discard;
    logic [NUM_SLOTS-1:0] freeMask;
    logic [NUM_SLOTS-1:0] freeOneHot;
    logic                 freeFound;
    logic [4:0]           hitCnt;
    logic [4:0]           missCnt;
    logic [31:0]          hitPts;
    logic [31:0]          scoreSum;
    logic [31:0]          comboSum;
    logic [31:0]          missSum;

    // The ROM reads the current pointer, so its output describes ptr_q one
    // cycle later; entryVld_q marks the cycles where that data is current.
    chart_rom #(
        .DEPTH (CHART_LEN),
        .AW    (AW),
        .INIT  (CHART_INIT)
    ) u_rom (
        .frame_clk (frame_clk),
        .addr_i    (ptr_q),
        .data_o    (entry)
    );

    assign startGame  = (state_q == S_IDLE) &&
                        ((keycode == KEY_START) || (keycode_second == KEY_START));
    assign restartKey = (keycode == KEY_RESTART) || (keycode_second == KEY_RESTART);

    // A slot launched in this cycle or the one before may not show busy yet,
    // so it is held out of the free pool. Lowest index wins.
    always_comb begin
        freeMask   = ~slot_busy & ~launch_q & ~launchPrev_q;
        freeFound  = 1'b0;
        freeOneHot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (freeMask[i]) begin
                freeFound     = 1'b1;
                freeOneHot    = '0;
                freeOneHot[i] = 1'b1;
            end
        end
    end

    // Game FSM, frame counter and chart walk. Consuming an entry (launch or
    // discard) advances the pointer and invalidates the entry for one cycle
    // while the ROM fetches the next word.
    always_comb begin
        state_d    = state_q;
        frameCnt_d = frameCnt_q;
        ptr_d      = ptr_q;
        entryVld_d = entryVld_q;
        launch_d   = '0;
        lane_d     = '0;
        discard    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (startGame) begin
                    state_d    = S_PLAY;
                    frameCnt_d = '0;
                    ptr_d      = '0;
                    entryVld_d = 1'b0;
                end
            end
            S_PLAY: begin
                if (frameCnt_q < FRAME_MAX) begin
                    frameCnt_d = frameCnt_q + 12'd1;
                end
                entryVld_d = 1'b1;
                if (entryVld_q) begin
                    if (entry.due == CHART_END) begin
                        state_d = S_DRAIN;
                    end else if (entry.due <= frameCnt_q) begin
                        if (freeFound) begin
                            launch_d = freeOneHot;
                            lane_d   = entry.lane;
                        end else begin
                            discard = 1'b1;
                        end
                        entryVld_d = 1'b0;
                        if (ptr_q == LAST_PTR) begin
                            state_d = S_DRAIN;
                        end else begin
                            ptr_d = ptr_q + AW'(1);
                        end
                    end
                end
            end
            S_DRAIN: begin
                if ((slot_busy == '0) && (slot_hit == '0) && (slot_miss == '0)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (restartKey) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Scoring: the bonus decision uses the combo held before this cycle's
    // hits. Any miss or dropped note breaks the combo.
    always_comb begin
        score_d  = score_q;
        combo_d  = combo_q;
        miss_d   = miss_q;
        hitCnt   = popcount16(16'(slot_hit));
        missCnt  = popcount16(16'(slot_miss));
        hitPts   = 32'(hitCnt) * HIT_POINTS;
        if (32'(combo_q) >= BONUS_COMBO) begin
            hitPts = hitPts + 32'(hitCnt) * BONUS_POINTS;
        end
        scoreSum = 32'(score_q) + hitPts;
        comboSum = 32'(combo_q) + 32'(hitCnt);
        missSum  = 32'(miss_q) + 32'(missCnt) + 32'(discard);
        if (startGame) begin
            score_d = '0;
            combo_d = '0;
            miss_d  = '0;
        end else if ((state_q == S_PLAY) || (state_q == S_DRAIN)) begin
            score_d = (scoreSum > 32'h0000_FFFF) ? 16'hFFFF : scoreSum[15:0];
            if ((missCnt != 5'd0) || discard) begin
                combo_d = '0;
            end else begin
                combo_d = (comboSum > 32'd255) ? 8'hFF : comboSum[7:0];
            end
            miss_d = (missSum > 32'd255) ? 8'hFF : missSum[7:0];
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            frameCnt_q   <= '0;
            ptr_q        <= '0;
            entryVld_q   <= 1'b0;
            launch_q     <= '0;
            launchPrev_q <= '0;
            lane_q       <= '0;
            score_q      <= '0;
            combo_q      <= '0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            frameCnt_q   <= frameCnt_d;
            ptr_q        <= ptr_d;
            entryVld_q   <= entryVld_d;
            launch_q     <= launch_d;
            launchPrev_q <= launch_q;
            lane_q       <= lane_d;
            score_q      <= score_d;
            combo_q      <= combo_d;
            miss_q       <= miss_d;
        end
    end

    assign launch      = launch_q;
    assign launch_lane = lane_q;
    assign score       = score_q;
    assign combo       = combo_q;
    assign miss_cnt    = miss_q;
    assign game_state  = state_q;

endmodule

// File: tb/tb_note_scheduler.sv
// ---------------------------------------------------------------------------
// tb_note_scheduler
// Directed bench for note_scheduler. A cycle-level behavioural model tracks
// what every output must be; a compare process checks the DUT against it
// after every clock edge, and the stimulus sequence pins the model with
// hand-computed literal values at the interesting points.
// ---------------------------------------------------------------------------
module tb_note_scheduler;

    localparam int NS    = 8;
    localparam int CLEN  = 8;
    localparam int BONUS = 12;

    // Chart: {5,lane0}, {5,lane2}, {30,lane1}, end markers.
    localparam logic [CLEN*14-1:0] CHART = {
        {4{14'h3FFF}},
        {12'hFFF, 2'd3},
        {12'd30,  2'd1},
        {12'd5,   2'd2},
        {12'd5,   2'd0}
    };

    int chartDue  [CLEN] = '{5, 5, 30, 4095, 4095, 4095, 4095, 4095};
    int chartLane [CLEN] = '{0, 2, 1, 3, 3, 3, 3, 3};

    logic          frame_clk = 1'b0;
    logic          Reset     = 1'b1;
    logic [7:0]    keycode        = 8'h00;
    logic [7:0]    keycode_second = 8'h00;
    logic [NS-1:0] slot_busy = '0;
    logic [NS-1:0] slot_hit  = '0;
    logic [NS-1:0] slot_miss = '0;
    logic [NS-1:0] launch;
    logic [1:0]    launch_lane;
    logic [15:0]   score;
    logic [7:0]    combo;
    logic [7:0]    miss_cnt;
    logic [1:0]    game_state;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    int expState, expScore, expCombo, expMiss, expLaunch, expLane;
    int mFrame, mIdx, mAvail;
    int cyc = 0;
    int lastLaunch [NS];

    note_scheduler #(
        .NUM_SLOTS   (NS),
        .CHART_LEN   (CLEN),
        .BONUS_COMBO (BONUS),
        .CHART_INIT  (CHART)
    ) dut (
        .frame_clk      (frame_clk),
        .Reset          (Reset),
        .keycode        (keycode),
        .keycode_second (keycode_second),
        .slot_busy      (slot_busy),
        .slot_hit       (slot_hit),
        .slot_miss      (slot_miss),
        .launch         (launch),
        .launch_lane    (launch_lane),
        .score          (score),
        .combo          (combo),
        .miss_cnt       (miss_cnt),
        .game_state     (game_state)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One cycle of scoring pulses, then back to quiet.
    task automatic applyStimulus(input logic [NS-1:0] hit, input logic [NS-1:0] miss);
        slot_hit  = hit;
        slot_miss = miss;
        @(negedge frame_clk);
        slot_hit  = '0;
        slot_miss = '0;
    endtask

    // Behavioural model: advances on each clock edge from the inputs present
    // before the edge. Cycle numbers stand in for the fetch bubble and the
    // recent-launch hold-off.
    always @(posedge frame_clk) begin : modelProc
        int h, m, add, disc, nState, nLaunch, nLane, slot;
        bit startKey, restartKey;
        if (Reset) begin
            expState = 0; expScore = 0; expCombo = 0; expMiss = 0;
            expLaunch = 0; expLane = 0;
            mFrame = 0; mIdx = 0; mAvail = 0;
            foreach (lastLaunch[i]) lastLaunch[i] = -100;
        end else begin
            h = $countones(slot_hit);
            m = $countones(slot_miss);
            startKey   = (keycode == 8'h2c) || (keycode_second == 8'h2c);
            restartKey = (keycode == 8'h01) || (keycode_second == 8'h01);
            nState = expState; nLaunch = 0; nLane = 0; disc = 0;
            case (expState)
                0: if (startKey) begin
                    nState = 1; mFrame = 0; mIdx = 0; mAvail = cyc + 2;
                end
                1: begin
                    if (cyc >= mAvail) begin
                        if (chartDue[mIdx] == 4095) begin
                            nState = 2;
                        end else if (chartDue[mIdx] <= mFrame) begin
                            slot = -1;
                            for (int i = 0; i < NS; i++) begin
                                if (slot < 0 && !slot_busy[i] && lastLaunch[i] < cyc - 1) slot = i;
                            end
                            if (slot >= 0) begin
                                nLaunch = 1 << slot;
                                nLane   = chartLane[mIdx];
                                lastLaunch[slot] = cyc + 1;
                            end else begin
                                disc = 1;
                            end
                            if (mIdx == CLEN - 1) nState = 2;
                            else mIdx = mIdx + 1;
                            mAvail = cyc + 2;
                        end
                    end
                    if (mFrame < 4094) mFrame = mFrame + 1;
                end
                2: if (slot_busy == '0 && slot_hit == '0 && slot_miss == '0) nState = 3;
                default: if (restartKey) nState = 0;
            endcase
            if (expState == 1 || expState == 2) begin
                add = h * 10 + ((expCombo >= BONUS) ? h * 5 : 0);
                expScore = (expScore + add > 65535) ? 65535 : expScore + add;
                if (m > 0 || disc != 0) expCombo = 0;
                else expCombo = (expCombo + h > 255) ? 255 : expCombo + h;
                expMiss = (expMiss + m + disc > 255) ? 255 : expMiss + m + disc;
            end else if (expState == 0 && startKey) begin
                expScore = 0; expCombo = 0; expMiss = 0;
            end
            expState  = nState;
            expLaunch = nLaunch;
            expLane   = nLane;
        end
        cyc = cyc + 1;
    end

    // Compare process: outputs against the model, just after every edge.
    always @(posedge frame_clk) begin
        #1;
        if (checking) begin
            checkOutput("state",    32'(game_state), expState);
            checkOutput("score",    32'(score),      expScore);
            checkOutput("combo",    32'(combo),      expCombo);
            checkOutput("miss_cnt", 32'(miss_cnt),   expMiss);
            checkOutput("launch",   32'(launch),     expLaunch);
            if (expLaunch != 0) checkOutput("launch_lane", 32'(launch_lane), expLane);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        repeat (2) @(negedge frame_clk);
        checking = 1'b1;
        checkOutput("rst_state", 32'(game_state), 0);
        checkOutput("rst_score", 32'(score), 0);
        checkOutput("rst_combo", 32'(combo), 0);
        checkOutput("rst_miss",  32'(miss_cnt), 0);
        checkOutput("rst_launch", 32'(launch), 0);
        checkOutput("rst_lane",  32'(launch_lane), 0);
        Reset = 1'b0;
        @(negedge frame_clk);

        // Start the song; PLAY begins at frame 0.
        keycode = 8'h2c;
        @(negedge frame_clk);
        keycode = 8'h00;
        checkOutput("start_state", 32'(game_state), 1);
        repeat (6) @(negedge frame_clk);
        checkOutput("launch0", 32'(launch), 32'h01);
        checkOutput("lane0",   32'(launch_lane), 0);
        @(negedge frame_clk);
        checkOutput("bubble", 32'(launch), 0);
        @(negedge frame_clk);
        checkOutput("launch1", 32'(launch), 32'h02);
        checkOutput("lane1",   32'(launch_lane), 2);

        // Every slot busy when the frame-30 note falls due: it is dropped.
        repeat (11) @(negedge frame_clk);
        slot_busy = 8'hFF;
        repeat (12) @(negedge frame_clk);
        checkOutput("drop_miss",   32'(miss_cnt), 1);
        checkOutput("drop_combo",  32'(combo), 0);
        checkOutput("drop_launch", 32'(launch), 0);
        @(negedge frame_clk);
        @(negedge frame_clk);
        checkOutput("drain_state", 32'(game_state), 2);

        // Scoring while draining, busy still held.
        for (int i = 0; i < 12; i++) applyStimulus(8'(1 << (i % 8)), 8'h00);
        checkOutput("hits12_score", 32'(score), 120);
        checkOutput("hits12_combo", 32'(combo), 12);
        applyStimulus(8'h30, 8'h00);
        checkOutput("pair_score", 32'(score), 150);
        checkOutput("pair_combo", 32'(combo), 14);
        applyStimulus(8'h00, 8'h01);
        checkOutput("miss_combo", 32'(combo), 0);
        checkOutput("miss_cnt2",  32'(miss_cnt), 2);
        for (int i = 0; i < 5; i++) applyStimulus(8'h40, 8'h00);
        checkOutput("hits5_combo", 32'(combo), 5);
        applyStimulus(8'h03, 8'h04);
        checkOutput("mixed_score", 32'(score), 220);
        checkOutput("mixed_combo", 32'(combo), 0);
        checkOutput("mixed_miss",  32'(miss_cnt), 3);

        repeat (2) @(negedge frame_clk);
        checkOutput("drain_hold", 32'(game_state), 2);
        slot_busy = '0;
        @(negedge frame_clk);
        checkOutput("done_state", 32'(game_state), 3);
        applyStimulus(8'h01, 8'h00);
        checkOutput("done_ignore", 32'(score), 220);
        keycode_second = 8'h01;
        @(negedge frame_clk);
        keycode_second = 8'h00;
        checkOutput("idle_state", 32'(game_state), 0);
        checkOutput("idle_score", 32'(score), 220);

        // Second run: reset lands in the cycle the first note falls due.
        keycode = 8'h2c;
        @(negedge frame_clk);
        keycode = 8'h00;
        checkOutput("replay_state", 32'(game_state), 1);
        checkOutput("replay_score", 32'(score), 0);
        repeat (5) @(negedge frame_clk);
        Reset = 1'b1;
        @(negedge frame_clk);
        checkOutput("midrst_launch", 32'(launch), 0);
        checkOutput("midrst_state",  32'(game_state), 0);
        checkOutput("midrst_miss",   32'(miss_cnt), 0);
        Reset = 1'b0;
        repeat (3) @(negedge frame_clk);
        checkOutput("post_launch", 32'(launch), 0);
        checkOutput("post_state",  32'(game_state), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
